// File: rtl/mix_char_conv.sv
// MIX CHAR unit: 30-bit binary magnitude -> ten MIX digit codes (30+digit) by serial double-dabble.
// Optional `busy` output when CHAR_BUSY_EN is defined.
module mix_char_conv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [29:0] in,
  output logic        stop,
  output logic [59:0] out
`ifdef CHAR_BUSY_EN
  ,
  output logic        busy
`endif
);

  localparam int NDIG = 10;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      r_state;
  logic [29:0] r_bin;
  logic [39:0] r_bcd;
  logic [4:0]  r_cnt;
  logic [39:0] w_adj;
  logic [59:0] w_chars;

  // Per-digit add-3 correction and character encoding
  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    logic [3:0] w_nib;
    assign w_nib               = r_bcd[4*k+3:4*k];
    assign w_adj[4*k+3:4*k]    = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
    assign w_chars[6*k+5:6*k]  = 6'd30 + {2'b00, w_nib};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      stop    <= 1'b0;
      out     <= '0;
    end else begin
      stop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_bcd <= {w_adj[38:0], r_bin[29]};
          r_bin <= {r_bin[28:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd29) r_state <= DONE;
        end
        DONE: begin
          out     <= w_chars;
          stop    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CHAR_BUSY_EN
  logic r_busy;
  // Busy stays up through DONE and drops on the following idle edge unless a new start arrives.
  always_ff @(posedge clk) begin
    if (reset)                r_busy <= 1'b0;
    else if (r_state == IDLE) r_busy <= start;
    else                      r_busy <= 1'b1;
  end
  assign busy = r_busy;
`endif

endmodule

// File: tb/tb_mix_char_conv.sv
// Directed self-checking bench for mix_char_conv; expected char words are hand-written byte lists.
module tb_mix_char_conv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [29:0] in;
  logic        stop;
  logic [59:0] out;
`ifdef CHAR_BUSY_EN
  logic        busy;
`endif

  int nchk  = 0;
  int nfail = 0;
  int lat;
  int nstop;

  mix_char_conv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in),
    .stop  (stop),
    .out   (out)
`ifdef CHAR_BUSY_EN
    ,
    .busy  (busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [59:0] pk(input int b9, b8, b7, b6, b5, b4, b3, b2, b1, b0);
    return {6'(b9), 6'(b8), 6'(b7), 6'(b6), 6'(b5), 6'(b4), 6'(b3), 6'(b2), 6'(b1), 6'(b0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start at E0, returns edges until stop (E31 expected) or -1 on timeout.
  task automatic run_conv(input logic [29:0] v, input int reissue, output int l);
    in    = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == reissue) begin
        start = 1'b1;
        in    = 30'd999;
      end
      tick();
      start = 1'b0;
`ifdef CHAR_BUSY_EN
      if (n == 1) check("busy_run", 64'(busy), 64'd1);
`endif
      if (stop) begin
        l = n;
        break;
      end
    end
  endtask

  logic [59:0] e_zero, e_12977, e_max, e_nine;

  initial begin
    e_zero  = pk(30, 30, 30, 30, 30, 30, 30, 30, 30, 30);
    e_12977 = pk(30, 30, 30, 30, 30, 31, 32, 39, 37, 37);
    e_max   = pk(31, 30, 37, 33, 37, 34, 31, 38, 32, 33);
    e_nine  = pk(30, 30, 30, 30, 30, 30, 30, 30, 30, 39);

    reset = 1'b1; start = 1'b0; in = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_stop", 64'(stop), 64'd0);
    check("rst_out", 64'(out), 64'd0);
`ifdef CHAR_BUSY_EN
    check("rst_busy", 64'(busy), 64'd0);
`endif
    tick();

    // zero input
    run_conv(30'd0, 0, lat);
    check("zero_lat", 64'(lat), 64'd31);
    check("zero_out", 64'(out), 64'(e_zero));
    tick();
    check("zero_pulse", 64'(stop), 64'd0);
`ifdef CHAR_BUSY_EN
    check("zero_busy_off", 64'(busy), 64'd0);
`endif

    // 12977
    run_conv(30'd12977, 0, lat);
    check("n12977_lat", 64'(lat), 64'd31);
    check("n12977_out", 64'(out), 64'(e_12977));
    tick();
    check("n12977_pulse", 64'(stop), 64'd0);

    // start reissued at E5 is ignored
    run_conv(30'd12977, 5, lat);
    check("reiss_lat", 64'(lat), 64'd31);
    check("reiss_out", 64'(out), 64'(e_12977));
    tick(); tick(); tick();
    check("reiss_hold", 64'(out), 64'(e_12977));

    // reset at E10 aborts, restart at E12 with max input
    in = 30'd12977; start = 1'b1;
    tick();
    start = 1'b0;
    nstop = 0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (stop) nstop++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out", 64'(out), 64'd0);
    check("abort_stop", 64'(stop), 64'd0);
`ifdef CHAR_BUSY_EN
    check("abort_busy", 64'(busy), 64'd0);
`endif
    tick();
    if (stop) nstop++;
    check("abort_nostop", 64'(nstop), 64'd0);
    run_conv(30'd1073741823, 0, lat);
    check("max_lat", 64'(lat), 64'd31);
    check("max_out", 64'(out), 64'(e_max));
    tick();

    // back-to-back: second start on E32
    run_conv(30'd12977, 0, lat);
    check("b2b1_lat", 64'(lat), 64'd31);
    check("b2b1_out", 64'(out), 64'(e_12977));
    run_conv(30'd9, 0, lat);
    check("b2b2_lat", 64'(lat), 64'd31);
    check("b2b2_out", 64'(out), 64'(e_nine));
    tick();
    check("b2b2_pulse", 64'(stop), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
